button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner.sv | 127 ++++++++++++
 tb/tb_button_conditioner.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Three-channel push-button conditioner: 2-flop synchroniser, per-channel debounce FSM,
// registered debounced level and one-cycle press pulse for each button.
module button_conditioner #(
  parameter int CNT_MAX = 499_999,
  parameter int CNT_W   = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_start,
  input  logic btn_stop,
  input  logic btn_inc,
  output logic start,
  output logic stop,
  output logic inc,
  output logic start_p,
  output logic stop_p,
  output logic inc_p
);

  typedef enum logic [1:0] {LOW, WAIT_H, HIGH, WAIT_L} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [2:0]       raw;
  logic [2:0]       sync_p0;
  logic [2:0]       sync_p1;
  state_t           state     [3];
  state_t           state_nxt [3];
  logic [CNT_W-1:0] cnt       [3];
  logic [CNT_W-1:0] cnt_nxt   [3];
  logic [2:0]       lvl;
  logic [2:0]       lvl_nxt;
  logic [2:0]       pls;
  logic [2:0]       pls_nxt;

  assign raw = {btn_inc, btn_stop, btn_start};

  // Stage p0/p1: metastability synchroniser; sync_p1 is the only view of the buttons downstream
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce FSM: a level is accepted only after CNT_MAX+1 consecutive agreeing samples
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      state_nxt[i] = state[i];
      cnt_nxt[i]   = cnt[i];
      pls_nxt[i]   = 1'b0;
      unique case (state[i])
        LOW: begin
          if (sync_p1[i]) begin
            state_nxt[i] = WAIT_H;
            cnt_nxt[i]   = '0;
          end
        end
        WAIT_H: begin
          if (!sync_p1[i]) begin
            state_nxt[i] = LOW;
            cnt_nxt[i]   = '0;
          end else if (cnt[i] == CNT_LAST) begin
            state_nxt[i] = HIGH;
            cnt_nxt[i]   = '0;
            pls_nxt[i]   = 1'b1;
          end else begin
            cnt_nxt[i] = cnt[i] + CNT_ONE;
          end
        end
        HIGH: begin
          if (!sync_p1[i]) begin
            state_nxt[i] = WAIT_L;
            cnt_nxt[i]   = '0;
          end
        end
        WAIT_L: begin
          if (sync_p1[i]) begin
            state_nxt[i] = HIGH;
            cnt_nxt[i]   = '0;
          end else if (cnt[i] == CNT_LAST) begin
            state_nxt[i] = LOW;
            cnt_nxt[i]   = '0;
          end else begin
            cnt_nxt[i] = cnt[i] + CNT_ONE;
          end
        end
        default: begin
          state_nxt[i] = LOW;
          cnt_nxt[i]   = '0;
        end
      endcase
      lvl_nxt[i] = (state_nxt[i] == HIGH) || (state_nxt[i] == WAIT_L);
    end
  end

  // Stage p2: FSM state, counters and registered outputs (decoded from next state)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        state[i] <= LOW;
        cnt[i]   <= '0;
      end
      lvl <= '0;
      pls <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        state[i] <= state_nxt[i];
        cnt[i]   <= cnt_nxt[i];
      end
      lvl <= lvl_nxt;
      pls <= pls_nxt;
    end
  end

  assign start   = lvl[0];
  assign stop    = lvl[1];
  assign inc     = lvl[2];
  assign start_p = pls[0];
  assign stop_p  = pls[1];
  assign inc_p   = pls[2];

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with CNT_MAX=15: table of timed vectors plus hand-written
// bounce, glitch and reset sequences, all checked through an expected-value queue.
module tb_button_conditioner;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn_start = 1'b0;
  logic btn_stop = 1'b0;
  logic btn_inc = 1'b0;
  logic start, stop, inc, start_p, stop_p, inc_p;

  always #5 clk = ~clk;

  button_conditioner #(.CNT_MAX(15), .CNT_W(5)) dut (
    .clk(clk), .reset(reset),
    .btn_start(btn_start), .btn_stop(btn_stop), .btn_inc(btn_inc),
    .start(start), .stop(stop), .inc(inc),
    .start_p(start_p), .stop_p(stop_p), .inc_p(inc_p)
  );

  // btn = {start, stop, inc}; exp = {start, stop, inc, start_p, stop_p, inc_p}
  typedef struct {
    logic       rst_n;
    logic [2:0] btn;
    int         cyc;
    logic [5:0] exp;
    string      name;
  } vec_t;

  vec_t       vecs [$];
  logic [5:0] exp_q [$];
  int         n_checks = 0;
  int         n_fail = 0;

  function automatic vec_t mk(input logic r, input logic [2:0] b, input int c,
                              input logic [5:0] e, input string nm);
    vec_t v;
    v.rst_n = r; v.btn = b; v.cyc = c; v.exp = e; v.name = nm;
    return v;
  endfunction

  function automatic logic [5:0] outs();
    return {start, stop, inc, start_p, stop_p, inc_p};
  endfunction

  task automatic check(input string nm);
    logic [5:0] e;
    logic [5:0] a;
    n_checks++;
    a = outs();
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: no expected entry queued, outputs %b", nm, a);
    end else begin
      e = exp_q.pop_front();
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: outputs %b, expected %b (t=%0t)", nm, a, e, $time);
      end
    end
  endtask

  // Drive inputs, queue the expectation, advance n clocks (n=0: no edge, just settle), compare
  task automatic step(input logic r, input logic [2:0] b, input int n,
                      input logic [5:0] e, input string nm);
    reset = r;
    {btn_start, btn_stop, btn_inc} = b;
    exp_q.push_back(e);
    if (n == 0) #1;
    else repeat (n) begin @(posedge clk); #1; end
    check(nm);
  endtask

  task automatic hold(input logic [2:0] b, input int n, input logic [5:0] e, input string nm);
    for (int k = 0; k < n; k++) step(1'b1, b, 1, e, nm);
  endtask

  initial begin
    // Reset held with random buttons: every output stays 0
    for (int k = 0; k < 10; k++) step(1'b0, 3'($urandom_range(0, 7)), 1, 6'b000000, "reset_random");

    vecs.push_back(mk(1, 3'b000, 50,  6'b000000, "idle_after_release"));
    vecs.push_back(mk(1, 3'b100, 18,  6'b000000, "start_before_window"));
    vecs.push_back(mk(1, 3'b100, 1,   6'b100100, "start_press_c19"));
    vecs.push_back(mk(1, 3'b100, 1,   6'b100000, "start_pulse_end_c20"));
    vecs.push_back(mk(1, 3'b100, 100, 6'b100000, "start_held_no_repeat"));
    vecs.push_back(mk(1, 3'b000, 18,  6'b100000, "start_release_pre"));
    vecs.push_back(mk(1, 3'b000, 1,   6'b000000, "start_release_c19"));
    vecs.push_back(mk(1, 3'b010, 18,  6'b000000, "stop_before_window"));
    vecs.push_back(mk(1, 3'b010, 1,   6'b010010, "stop_press_c19"));
    vecs.push_back(mk(1, 3'b010, 20,  6'b010000, "stop_held"));
    vecs.push_back(mk(1, 3'b000, 18,  6'b010000, "stop_fall_pre"));
    vecs.push_back(mk(1, 3'b000, 1,   6'b000000, "stop_fall_c19"));
    vecs.push_back(mk(1, 3'b111, 18,  6'b000000, "all_before_window"));
    vecs.push_back(mk(1, 3'b111, 1,   6'b111111, "all_press_c19"));
    vecs.push_back(mk(1, 3'b111, 1,   6'b111000, "all_pulse_end"));
    vecs.push_back(mk(1, 3'b000, 18,  6'b111000, "all_release_pre"));
    vecs.push_back(mk(1, 3'b000, 1,   6'b000000, "all_release_c19"));

    foreach (vecs[i]) step(vecs[i].rst_n, vecs[i].btn, vecs[i].cyc, vecs[i].exp, vecs[i].name);

    // Bouncing inc: high bursts of 3, 7 and 12 cycles are rejected, final hold accepted
    hold(3'b001, 3,  6'b000000, "inc_bounce_h3");
    hold(3'b000, 3,  6'b000000, "inc_bounce_l");
    hold(3'b001, 7,  6'b000000, "inc_bounce_h7");
    hold(3'b000, 3,  6'b000000, "inc_bounce_l");
    hold(3'b001, 12, 6'b000000, "inc_bounce_h12");
    hold(3'b000, 3,  6'b000000, "inc_bounce_l");
    hold(3'b001, 18, 6'b000000, "inc_final_pre");
    step(1'b1, 3'b001, 1, 6'b001001, "inc_press_c19");
    hold(3'b001, 10, 6'b001000, "inc_held");
    hold(3'b000, 18, 6'b001000, "inc_release_pre");
    step(1'b1, 3'b000, 1, 6'b000000, "inc_release_c19");

    // Held stop with a 10-cycle low glitch: level stays, no second pulse
    hold(3'b010, 18, 6'b000000, "stop2_pre");
    step(1'b1, 3'b010, 1, 6'b010010, "stop2_press_c19");
    hold(3'b010, 5,  6'b010000, "stop2_held");
    hold(3'b000, 10, 6'b010000, "stop_glitch_low");
    hold(3'b010, 30, 6'b010000, "stop_after_glitch");

    // Asynchronous reset with a level high: clears without a clock edge
    step(1'b0, 3'b010, 0, 6'b000000, "async_reset_clears");
    step(1'b0, 3'b010, 2, 6'b000000, "reset_held");
    hold(3'b000, 20, 6'b000000, "idle_after_reset");

    // Reset mid-window: press aborted, held button seen as new press after release
    hold(3'b100, 8, 6'b000000, "start_window_partial");
    step(1'b0, 3'b100, 0, 6'b000000, "midwin_reset_async");
    step(1'b0, 3'b100, 1, 6'b000000, "midwin_reset_c1");
    step(1'b0, 3'b100, 1, 6'b000000, "midwin_reset_c2");
    hold(3'b100, 18, 6'b000000, "post_reset_pre");
    step(1'b1, 3'b100, 1, 6'b100100, "post_reset_press_c19");
    hold(3'b100, 30, 6'b100000, "post_reset_single_pulse");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
